// File: rtl/mvu_weight_streamer.sv
// Weight-memory read master: replays WMEM_DEPTH words NUM_REPS times per frame as a valid/ready stream.
// Optional stall-cycle counter port is enabled by defining MVU_WSTREAM_PERF_EN.
module mvu_weight_streamer #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1,
    parameter int NUM_REPS     = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_data,
    output logic [SIMD*TW-1:0]      wout_data,
    output logic                    wout_valid,
    input  logic                    wout_ready,
`ifdef MVU_WSTREAM_PERF_EN
    output logic                    wout_last,
    output logic [31:0]             stall_cycles
`else
    output logic                    wout_last
`endif
);

    localparam int W      = SIMD * TW;
    localparam int REP_BW = (NUM_REPS > 1) ? $clog2(NUM_REPS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                  state_reg, state_next;
    logic [WMEM_ADDR_BW-1:0] addr_reg;
    logic [REP_BW-1:0]       rep_reg;
    logic                    inflight_reg;
    logic                    inflight_last_reg;

    // Two-entry FIFO; bit W of each entry carries the last-word flag.
    logic [W:0]              fifo_mem [2];
    logic                    rd_ptr_reg, wr_ptr_reg;
    logic [1:0]              count_reg;

    logic       push, pop, issue, addr_last, rep_last, issue_last, drain_done, accept;
    logic [2:0] occupancy;
    logic [W:0] head;

    assign push       = inflight_reg;
    assign pop        = (count_reg != 2'd0) && wout_ready;
    // Credit includes this cycle's pop so a steady stream needs no bubble cycles.
    assign occupancy  = 3'(count_reg) + 3'(inflight_reg) - 3'(pop);
    assign issue      = (state_reg == S_RUN) && (occupancy < 3'd2);
    assign addr_last  = (addr_reg == WMEM_ADDR_BW'(WMEM_DEPTH - 1));
    assign rep_last   = (rep_reg == REP_BW'(NUM_REPS - 1));
    assign issue_last = addr_last && rep_last;
    assign drain_done = (state_reg == S_DRAIN) && (count_reg == 2'd0) && !inflight_reg;
    assign accept     = (state_reg == S_IDLE) && start;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (issue && issue_last) state_next = S_DRAIN;
            S_DRAIN: if (drain_done) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            addr_reg          <= '0;
            rep_reg           <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            inflight_reg      <= issue;
            inflight_last_reg <= issue && issue_last;
            if (accept) begin
                addr_reg <= '0;
                rep_reg  <= '0;
            end else if (issue) begin
                if (addr_last) begin
                    addr_reg <= '0;
                    rep_reg  <= rep_last ? '0 : rep_reg + REP_BW'(1);
                end else begin
                    addr_reg <= addr_reg + WMEM_ADDR_BW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) fifo_mem[i] <= '0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= {inflight_last_reg, wmem_data};
                wr_ptr_reg           <= ~wr_ptr_reg;
            end
            if (pop) rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    assign head       = fifo_mem[rd_ptr_reg];
    assign wout_valid = (count_reg != 2'd0);
    assign wout_data  = head[W-1:0];
    assign wout_last  = wout_valid && head[W];
    assign wmem_addr  = addr_reg;
    assign busy       = (state_reg != S_IDLE);
    assign done       = drain_done;

`ifdef MVU_WSTREAM_PERF_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if (wout_valid && !wout_ready && !(&stall_cycles)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mvu_weight_streamer.sv
// Scoreboard bench for mvu_weight_streamer: stimulus queues expected words, a negedge monitor checks them.
module tb_mvu_weight_streamer;

    localparam int SIMD  = 4;
    localparam int TW    = 2;
    localparam int W     = SIMD * TW;
    localparam int DEPTH = 4;
    localparam int REPS  = 2;
    localparam int AW    = 2;

    logic          clock = 1'b0;
    logic          reset, start, busy, done, wout_valid, wout_ready, wout_last;
    logic [AW-1:0] wmem_addr;
    logic [W-1:0]  wmem_data = '0;
    logic [W-1:0]  wout_data;
`ifdef MVU_WSTREAM_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    mvu_weight_streamer #(
        .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(AW), .NUM_REPS(REPS)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
        .wmem_addr(wmem_addr), .wmem_data(wmem_data),
        .wout_data(wout_data), .wout_valid(wout_valid), .wout_ready(wout_ready),
`ifdef MVU_WSTREAM_PERF_EN
        .wout_last(wout_last), .stall_cycles(stall_cycles)
`else
        .wout_last(wout_last)
`endif
    );

    always #5 clock = ~clock;

    logic [W-1:0] mem [DEPTH];
    initial begin
        mem[0] = 8'hA0; mem[1] = 8'hA1; mem[2] = 8'hA2; mem[3] = 8'hA3;
    end
    always @(posedge clock) wmem_data <= mem[wmem_addr];

    int checks   = 0;
    int failures = 0;
    int hs_count = 0;
    logic [W:0] sb [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        for (int r = 0; r < REPS; r++)
            for (int a = 0; a < DEPTH; a++)
                sb.push_back({(r == REPS - 1) && (a == DEPTH - 1), mem[a]});
    endtask

    // Monitor: pops expectations on handshake and checks hold-stability under backpressure.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(wout_valid), 32'd1);
                chk("hold_data", 32'(wout_data), 32'(prev_data));
                chk("hold_last", 32'(wout_last), 32'(prev_last));
            end
            if (wout_valid && wout_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'(wout_data), 32'hFFFF_FFFF);
                end else begin
                    logic [W:0] e;
                    e = sb.pop_front();
                    chk("word_data", 32'(wout_data), 32'(e[W-1:0]));
                    chk("word_last", 32'(wout_last), 32'(e[W]));
                end
                hs_count++;
                $display("txn %0d data=%h last=%b t=%0t", hs_count, wout_data, wout_last, $time);
            end
            prev_stall = wout_valid && !wout_ready;
            prev_data  = wout_data;
            prev_last  = wout_last;
        end
    end

    task automatic start_frame();
        @(posedge clock); #1;
        start = 1'b1;
        push_frame();
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int mode);
        logic [3:0] pat;
        bit seen;
        pat  = 4'b1001;
        seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clock); #1;
            if (done) begin
                seen = 1;
                break;
            end
            if (mode != 0) wout_ready = pat[k % 4];
        end
        wout_ready = 1'b1;
        chk("done_seen", 32'(seen), 32'd1);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_hs(input int target);
        bit ok;
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            if (hs_count >= target) begin
                ok = 1;
                break;
            end
            @(posedge clock); #1;
        end
        chk("hs_reached", 32'(ok), 32'd1);
    endtask

    initial begin
        int base;
        logic [AW-1:0] held;
        reset = 1'b1; start = 1'b0; wout_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_addr", 32'(wmem_addr), 32'd0);
        chk("rst_valid", 32'(wout_valid), 32'd0);
        chk("rst_last", 32'(wout_last), 32'd0);
        chk("rst_data", 32'(wout_data), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        // Frame with ready held high: latency, no bubbles, last flag, done timing.
        base = hs_count;
        start_frame();
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_addr", 32'(wmem_addr), 32'd0);
        chk("c1_valid", 32'(wout_valid), 32'd0);
        @(posedge clock); #1;
        chk("e1_valid", 32'(wout_valid), 32'd0);
        @(posedge clock); #1;
        chk("first_valid", 32'(wout_valid), 32'd1);
        chk("first_data", 32'(wout_data), 32'hA0);
        for (int i = 0; i < 8; i++) begin
            chk("no_bubble", 32'(wout_valid), 32'd1);
            chk("last_pos", 32'(wout_last), 32'(i == 7));
            @(posedge clock); #1;
        end
        chk("done_pulse", 32'(done), 32'd1);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("done_low", 32'(done), 32'd0);
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        chk("frame_words", 32'(hs_count - base), 32'd8);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // Ready toggling pattern.
        start_frame();
        wait_done(1);

        // Ready low for 10 cycles mid-frame.
        start_frame();
        wait_hs(hs_count + 3);
        wout_ready = 1'b0;
        @(posedge clock); #1;
        held = wmem_addr;
        for (int i = 0; i < 9; i++) begin
            @(posedge clock); #1;
            chk("addr_frozen", 32'(wmem_addr), 32'(held));
        end
        wout_ready = 1'b1;
        wait_done(0);

        // Reset at word 3 of 8, then a full restart.
        start_frame();
        wait_hs(hs_count + 3);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(wout_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_addr", 32'(wmem_addr), 32'd0);
        chk("mid_rst_data", 32'(wout_data), 32'd0);
        sb.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        base = hs_count;
        start_frame();
        wait_done(0);
        chk("restart_words", 32'(hs_count - base), 32'd8);

`ifdef MVU_WSTREAM_PERF_EN
        start_frame();
        wait_hs(hs_count + 2);
        wout_ready = 1'b0;
        repeat (5) @(posedge clock);
        #1 wout_ready = 1'b1;
        wait_done(0);
        chk("stall_cycles", stall_cycles, 32'd5);
        start_frame();
        chk("stall_cleared", stall_cycles, 32'd0);
        wait_done(0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
